// File: rtl/snk_linebuf_pkg.sv
// Shared types and constants for the ping-pong sprite line buffer.
// Holds the FSM state enum and the default transparent pixel value.
package snk_linebuf_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lb_state_e;

    // All ones; the top slices this down to PIX_W bits.
    localparam logic [31:0] LB_TRANSP_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/snk_linebuf_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: clk_i; we_i/wa_i/wd_i write; re_i/ra_i read, rd_o one clk later.
module snk_linebuf_dpram #(
    parameter int W     = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic          re_i,
    input  logic [AW-1:0] ra_i,
    output logic [W-1:0]  rd_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_q;

    // Read-first: a read and write to one address in one cycle
    // returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wa_i] <= wd_i;
        if (re_i) rd_q <= mem_q[ra_i];
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/snk_linebuf_pingpong.sv
// Ping-pong sprite line buffer: one bank filled while the other is read.
// Ports: clk, reset (sync, high), line_start, flip, wr_en/wr_x/wr_data,
// rd_cen, rd_data, busy, drop_cnt. Macro LINEBUF_DROP_CNT_EN enables
// the dropped-write counter; otherwise drop_cnt is tied to 0.
module snk_linebuf_pingpong
    import snk_linebuf_pkg::*;
#(
    parameter int               PIX_W      = 8,
    parameter int               XW         = 9,
    parameter int               LINE_LEN   = 256,
    parameter logic [PIX_W-1:0] TRANSP     = LB_TRANSP_DEF[PIX_W-1:0],
    parameter bit               PRIO_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic             flip,
    input  logic             wr_en,
    input  logic [XW-1:0]    wr_x,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_cen,
    output logic [PIX_W-1:0] rd_data,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam int CW = XW + 1;
    localparam int AW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [CW-1:0] LEN      = CW'(LINE_LEN);
    localparam logic [CW-1:0] CLR_LAST = CW'(2 * LINE_LEN - 1);

    lb_state_e     state_q, state_d;
    logic [CW-1:0] clr_q, clr_d;
    logic          bank_q, flip_q;
    logic [CW-1:0] idx_q;

    logic          run, ls, rd_act, rd_sat, wr_ok, s0_v, s0_bank;
    logic [AW-1:0] rd_addr;

    logic             s1_v_q, s1_bank_q, s1_st;
    logic [AW-1:0]    s1_x_q;
    logic [PIX_W-1:0] s1_d_q, s1_old;

    logic             ram_we [2];
    logic             ram_re [2];
    logic [AW-1:0]    ram_wa [2];
    logic [AW-1:0]    ram_ra [2];
    logic [PIX_W-1:0] ram_wd [2];
    logic [PIX_W-1:0] ram_rd [2];

    logic             bw_we_q [2];
    logic [AW-1:0]    bw_wa_q [2];
    logic [PIX_W-1:0] bw_wd_q [2];

    logic             rd_pend_q, rd_src_q;
    logic [PIX_W-1:0] rd_hold_q, rd_pix;

    assign run     = (state_q == ST_RUN);
    assign busy    = ~run;
    assign ls      = run & line_start;
    // line_start owns the cycle; a coincident rd_cen is not a read.
    assign rd_act  = run & rd_cen & ~line_start & (idx_q < LEN);
    assign rd_sat  = run & rd_cen & ~line_start & ~(idx_q < LEN);
    assign rd_addr = flip_q ? AW'(LEN - CW'(1) - idx_q) : AW'(idx_q);
    assign wr_ok   = ({1'b0, wr_x} < LEN);
    assign s0_v    = run & wr_en & wr_ok & (wr_data != TRANSP);
    // A write alongside line_start goes to the bank being filled for
    // the following line, keeping it away from the bank now read.
    assign s0_bank = ls ? bank_q : ~bank_q;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == ST_CLEAR) begin
            clr_d = clr_q + CW'(1);
            if (clr_q == CLR_LAST) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // The RAM read issued last cycle missed the write committed on the
    // same edge; take that write instead when it hit the same entry.
    assign s1_old = (bw_we_q[s1_bank_q] && bw_wa_q[s1_bank_q] == s1_x_q)
                  ? bw_wd_q[s1_bank_q] : ram_rd[s1_bank_q];
    assign s1_st  = s1_v_q & (PRIO_FIRST ? (s1_old == TRANSP) : 1'b1);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            ram_we[b] = 1'b0;
            ram_wa[b] = '0;
            ram_wd[b] = TRANSP;
            ram_re[b] = 1'b0;
            ram_ra[b] = '0;
            if (!run) begin
                // Sweep bank 0 then bank 1, one entry per cycle.
                ram_we[b] = (b == 0) ? (clr_q < LEN) : (clr_q >= LEN);
                ram_wa[b] = (b == 0) ? AW'(clr_q) : AW'(clr_q - LEN);
            end else begin
                if (s1_st && s1_bank_q == 1'(b)) begin
                    ram_we[b] = 1'b1;
                    ram_wa[b] = s1_x_q;
                    ram_wd[b] = s1_d_q;
                end else if (rd_act && bank_q == 1'(b)) begin
                    ram_we[b] = 1'b1;
                    ram_wa[b] = rd_addr;
                end
                if (s0_v && s0_bank == 1'(b)) begin
                    ram_re[b] = 1'b1;
                    ram_ra[b] = AW'(wr_x);
                end else if (rd_act && bank_q == 1'(b)) begin
                    ram_re[b] = 1'b1;
                    ram_ra[b] = rd_addr;
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        snk_linebuf_dpram #(
            .W     (PIX_W),
            .AW    (AW),
            .DEPTH (LINE_LEN)
        ) u_ram (
            .clk_i (clk),
            .we_i  (ram_we[g]),
            .wa_i  (ram_wa[g]),
            .wd_i  (ram_wd[g]),
            .re_i  (ram_re[g]),
            .ra_i  (ram_ra[g]),
            .rd_o  (ram_rd[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            bw_we_q[b] <= reset ? 1'b0 : ram_we[b];
            bw_wa_q[b] <= ram_wa[b];
            bw_wd_q[b] <= ram_wd[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= 1'b0;
            flip_q <= 1'b0;
            idx_q  <= '0;
            s1_v_q <= 1'b0;
        end else begin
            if (ls) begin
                bank_q <= ~bank_q;
                flip_q <= flip;
                idx_q  <= '0;
            end else if (rd_act) begin
                idx_q <= idx_q + CW'(1);
            end
            s1_v_q <= s0_v;
        end
        s1_bank_q <= s0_bank;
        s1_x_q    <= AW'(wr_x);
        s1_d_q    <= wr_data;
    end

    // The bank read port is shared with the write side after a swap,
    // so the shown pixel is captured into a hold register.
    assign rd_pix  = rd_pend_q ? ram_rd[rd_src_q] : rd_hold_q;
    assign rd_data = rd_pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_src_q  <= 1'b0;
            rd_hold_q <= TRANSP;
        end else begin
            rd_pend_q <= rd_act;
            rd_src_q  <= bank_q;
            rd_hold_q <= rd_sat ? TRANSP : rd_pix;
        end
    end

`ifdef LINEBUF_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = run & wr_en & ~wr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else if (ls) begin
            drop_q <= {7'd0, drop};
        end else if (drop && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_snk_linebuf_pingpong.sv
// Directed bench for snk_linebuf_pingpong at default parameters.
// Drop-count checks follow whether LINEBUF_DROP_CNT_EN is defined.
module tb_snk_linebuf_pingpong;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line_start = 1'b0;
    logic       flip = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] wr_x = '0;
    logic [7:0] wr_data = '0;
    logic       rd_cen = 1'b0;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int n_busy;
    logic [7:0] rbuf [0:511];

`ifdef LINEBUF_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    snk_linebuf_pingpong dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .flip       (flip),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_data    (wr_data),
        .rd_cen     (rd_cen),
        .rd_data    (rd_data),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ls_pulse(input logic f);
        line_start = 1'b1;
        flip = f;
        tick();
        line_start = 1'b0;
        flip = 1'b0;
    endtask

    task automatic wr(input int x, input logic [7:0] d);
        wr_en = 1'b1;
        wr_x = x[8:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_cen = 1'b1;
            tick();
            rbuf[i] = rd_data;
        end
        rd_cen = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    function automatic int n_opaque(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++)
            if (rbuf[i] !== 8'hFF) c++;
        return c;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_rd", 32'(rd_data), 32'hFF);
        chk("rst_drop", 32'(drop_cnt), 0);
        reset = 1'b0;
        wait_clear(n_busy);
        chk("busy_len", n_busy, 512);
        chk("busy_low", 32'(busy), 0);

        ls_pulse(1'b0);
        rd_n(257);
        chk("clr_line", n_opaque(0, 256), 0);

        wr(10, 8'h12);
        wr(10, 8'h34);
        wr(20, 8'h40);
        tick();
        wr(20, 8'h41);
        ls_pulse(1'b0);
        rd_n(11);
        chk("prio_first", 32'(rbuf[10]), 32'h12);
        chk("prio_pre", 32'(rbuf[9]), 32'hFF);
        repeat (3) tick();
        chk("hold", 32'(rd_data), 32'h12);
        rd_n(11);
        chk("prio_gap", 32'(rbuf[9]), 32'h40);
        ls_pulse(1'b0);
        ls_pulse(1'b0);
        rd_n(21);
        chk("reread_clr", n_opaque(0, 20), 0);

        wr(0, 8'h05);
        ls_pulse(1'b1);
        rd_n(258);
        chk("flip_first", 32'(rbuf[0]), 32'hFF);
        chk("flip_last", 32'(rbuf[255]), 32'h05);
        chk("flip_sat", 32'(rbuf[256]), 32'hFF);
        chk("flip_sat2", 32'(rbuf[257]), 32'hFF);
        chk("flip_rest", n_opaque(1, 254), 0);

        line_start = 1'b1;
        wr(7, 8'h22);
        line_start = 1'b0;
        rd_n(8);
        chk("ls_wr_next", 32'(rbuf[7]), 32'hFF);
        ls_pulse(1'b0);
        rd_n(8);
        chk("ls_wr_later", 32'(rbuf[7]), 32'h22);

        wr(300, 8'h01);
        wr(511, 8'h01);
        chk("drop2", 32'(drop_cnt), DROP_EN ? 2 : 0);
        ls_pulse(1'b0);
        chk("drop_clr", 32'(drop_cnt), 0);
        rd_n(256);
        chk("drop_noop", n_opaque(0, 255), 0);
        for (int k = 0; k < 300; k++) wr(300, 8'h01);
        chk("drop_sat", 32'(drop_cnt), DROP_EN ? 255 : 0);
        line_start = 1'b1;
        wr(400, 8'h01);
        line_start = 1'b0;
        chk("drop_ls", 32'(drop_cnt), DROP_EN ? 1 : 0);

        wr(50, 8'h77);
        wr(150, 8'h66);
        ls_pulse(1'b0);
        wr(60, 8'h55);
        rd_n(100);
        chk("pre_rst", 32'(rbuf[50]), 32'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_rd", 32'(rd_data), 32'hFF);
        chk("rst2_busy", 32'(busy), 1);
        wait_clear(n_busy);
        chk("rst2_len", n_busy, 512);
        ls_pulse(1'b0);
        rd_n(256);
        chk("rst2_lineA", n_opaque(0, 255), 0);
        ls_pulse(1'b0);
        rd_n(256);
        chk("rst2_lineB", n_opaque(0, 255), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
